// File: rtl/poly_eval_seq_pkg.sv
// poly_pkg: types and elaboration-time helpers shared by poly_eval_seq and its bench.
//   state_e  : evaluator FSM states, 2-bit encoding
//   clog2    : ceiling log2 for sizing counters
//   zw_calc  : result width, max(2*xw, yw) + 1
package poly_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int zw_calc(input int xw, input int yw);
      return ((2 * xw > yw) ? 2 * xw : yw) + 1;
   endfunction

endpackage

// File: rtl/poly_eval_seq_rca.sv
// rca_n: parametrised ripple-carry adder.
//   a, b  : WIDTH-bit addends
//   cin   : carry in
//   sum   : WIDTH-bit sum
//   cout  : carry out of the top bit
module rca_n #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/poly_eval_seq.sv
// poly_eval_seq: sequential evaluator of z = x*x + 2*x + y on a valid/ready stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (x, y)
//   out_valid / out_ready: result handshake (z)
//   busy                 : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | XW shift-add steps building x*x in acc
// ADD   | single step, z <= acc + 2*x + y
// DONE  | z presented, held until out_ready
module poly_eval_seq
   import poly_pkg::*;
#(
   parameter  int XW = 2,
   parameter  int YW = 4,
   localparam int ZW = zw_calc(XW, YW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [ZW-1:0] z,
   output logic          busy
);

   localparam int CW = clog2(XW + 1);

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [ZW-1:0] mcand_q, mcand_d;
   logic [XW-1:0] mplier_q, mplier_d;
   logic [ZW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ZW-1:0] z_q, z_d;

   logic [ZW-1:0] x2_ext, y_ext, sum_ax, sum_axy;
   logic          cout_ax_unused, cout_axy_unused;

   // Every addend fits well inside ZW bits, so both carry-outs are always zero.
   assign x2_ext = ZW'({x_q, 1'b0});
   assign y_ext  = ZW'(y_q);

   rca_n #(.WIDTH(ZW)) u_add_ax (
      .a    (acc_q),
      .b    (x2_ext),
      .cin  (1'b0),
      .sum  (sum_ax),
      .cout (cout_ax_unused)
   );

   rca_n #(.WIDTH(ZW)) u_add_axy (
      .a    (sum_ax),
      .b    (y_ext),
      .cin  (1'b0),
      .sum  (sum_axy),
      .cout (cout_axy_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         z_q      <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         z_q      <= z_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      z_d      = z_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d      = x;
               y_d      = y;
               mcand_d  = ZW'(x);
               mplier_d = x;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = MUL;
            end
         end
         MUL: begin
            // Multiplicand and multiplier shift each step, so the current
            // partial product is always mcand_q gated by mplier_q[0].
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(XW - 1)) begin
               state_d = ADD;
            end
         end
         ADD: begin
            z_d     = sum_axy;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign z         = z_q;

endmodule

// File: tb/tb_poly_eval_seq.sv
module tb_poly_eval_seq;
   import poly_pkg::*;

   localparam int XA = 2;
   localparam int YA = 4;
   localparam int ZA = zw_calc(XA, YA);
   localparam int XB = 4;
   localparam int YB = 4;
   localparam int ZB = zw_calc(XB, YB);
   localparam int XC = 1;
   localparam int YC = 1;
   localparam int ZC = zw_calc(XC, YC);

   logic clk;
   logic rst_n;

   logic          in_valid, in_ready, out_valid, out_ready, busy;
   logic [XA-1:0] x;
   logic [YA-1:0] y;
   logic [ZA-1:0] z;

   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [XB-1:0] b_x;
   logic [YB-1:0] b_y;
   logic [ZB-1:0] b_z;

   logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
   logic [XC-1:0] c_x;
   logic [YC-1:0] c_y;
   logic [ZC-1:0] c_z;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   poly_eval_seq #(.XW(XA), .YW(YA)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .z(z), .busy(busy)
   );

   poly_eval_seq #(.XW(XB), .YW(YB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .x(b_x), .y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready), .z(b_z), .busy(b_busy)
   );

   poly_eval_seq #(.XW(XC), .YW(YC)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .x(c_x), .y(c_y), .out_valid(c_out_valid), .out_ready(c_out_ready), .z(c_z), .busy(c_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ref_z(input int xi, input int yi);
      return xi * xi + 2 * xi + yi;
   endfunction

   // Protocol monitor on the default instance, sampled on the falling edge.
   logic          hold_prev = 1'b0;
   logic [ZA-1:0] z_prev    = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         chk("rdy_with_vld", in_ready & out_valid, 0);
         if (hold_prev) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_z", z, z_prev);
         end
         hold_prev = out_valid & ~out_ready;
         z_prev    = z;
      end
   end

   // Default instance with out_ready high; caller guarantees in_ready is high.
   task automatic run_a(input int xi, input int yi, input int exp_z, input string tag);
      int lat;
      x = XA'(xi); y = YA'(yi); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         chk({tag, "_rdy_low"}, in_ready, 0);
         chk({tag, "_busy"}, busy, 1);
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, XA + 1);
      chk({tag, "_z"}, z, exp_z);
      @(posedge clk); #1;
      chk({tag, "_idle_rdy"}, in_ready, 1);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_vld"}, out_valid, 0);
   endtask

   task automatic run_b(input int xi, input int yi, input int exp_z, input string tag);
      int lat;
      b_x = XB'(xi); b_y = YB'(yi); b_in_valid = 1'b1; b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, XB + 1);
      chk({tag, "_z"}, b_z, exp_z);
      @(posedge clk); #1;
   endtask

   task automatic run_c(input int xi, input int yi, input int exp_z, input string tag);
      int lat;
      c_x = XC'(xi); c_y = YC'(yi); c_in_valid = 1'b1; c_out_ready = 1'b1;
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      lat = 0;
      while (!c_out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, lat, XC + 1);
      chk({tag, "_z"}, c_z, exp_z);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0;
      c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", in_ready, 1);
      chk("rst_vld", out_valid, 0);
      chk("rst_z", z, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 9 + 6 + 15
      run_a(3, 15, 30, "basic");

      // Back-to-back with in_valid held high. Each result needs IDLE, two MUL
      // steps, ADD and DONE, so results are spaced XW+3 = 5 cycles apart.
      fork
         begin
            int vx[3] = '{0, 2, 1};
            int vy[3] = '{0, 5, 0};
            for (int k = 0; k < 3; k++) begin
               int guard;
               x = XA'(vx[k]); y = YA'(vy[k]); in_valid = 1'b1;
               guard = 0;
               while (!in_ready && guard < 20) begin
                  @(posedge clk); #1;
                  guard++;
               end
               chk("b2b_accept_wait", guard < 20, 1);
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            int ez[3] = '{0, 13, 3};
            int t[3];
            for (int k = 0; k < 3; k++) begin
               int guard;
               guard = 0;
               while (!out_valid && guard < 40) begin
                  @(posedge clk); #1;
                  guard++;
               end
               chk("b2b_z", z, ez[k]);
               t[k] = cyc;
               @(posedge clk); #1;
            end
            chk("b2b_gap0", t[1] - t[0], XA + 3);
            chk("b2b_gap1", t[2] - t[1], XA + 3);
         end
      join

      // Backpressure: 9 + 6 + 1 = 16, held for 10 cycles while new operands are offered.
      begin
         int lat;
         x = 2'd3; y = 4'd1; in_valid = 1'b1; out_ready = 1'b0;
         @(posedge clk); #1;
         x = 2'd0; y = 4'd0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("bp_lat", lat, XA + 1);
         chk("bp_z", z, 16);
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_vld_held", out_valid, 1);
            chk("bp_z_held", z, 16);
            chk("bp_rdy_low", in_ready, 0);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         chk("bp_release_vld", out_valid, 0);
         chk("bp_release_rdy", in_ready, 1);
         chk("bp_release_busy", busy, 0);
         chk("bp_z_kept", z, 16);
      end

      // Reset between edges while in MUL.
      x = 2'd2; y = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_busy_before", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", out_valid, 0);
      chk("mid_rst_rdy", in_ready, 1);
      chk("mid_rst_z", z, 0);
      chk("mid_rst_busy", busy, 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_a(1, 2, 5, "post_rst");

      // Wider instance: 225 + 30 + 15, then every operand pair.
      run_b(15, 15, 270, "b_max");
      for (int xi = 0; xi < 16; xi++)
         for (int yi = 0; yi < 16; yi++)
            run_b(xi, yi, ref_z(xi, yi), "b_sweep");

      // Single-bit instance: 1 + 2 + 1, then all four pairs.
      run_c(1, 1, 4, "c_max");
      for (int xi = 0; xi < 2; xi++)
         for (int yi = 0; yi < 2; yi++)
            run_c(xi, yi, ref_z(xi, yi), "c_sweep");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
